timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Programmable seconds-timer controller for the RISC-V timer peripheral. It generates a once-per-second tick from the system clock with a prescaler instead of a divider, and sequences a 32-bit seconds counter through idle, run and expired states. It raises a compare-match interrupt in one-shot or periodic mode. The processor configures it and reads it back through a simple single-cycle register port.

## Interface
- CLK_HZ, 80000000, clock cycles per second; prescaler terminal count is CLK_HZ-1 (must be ≥2).
- PRESC_W, 27, prescaler width; must satisfy 2^PRESC_W ≥ CLK_HZ.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  register write strobe, one cycle per write.
- addr  in  2  register select: 0 CTRL, 1 COMPARE, 2 SECONDS, 3 STATUS.
- wdata  in  32  write data.
- rdata  out  32  combinational read of register at addr; unused bits read 0.
- seconds  out  32  current seconds count (registered).
- tick  out  1  one-cycle pulse on each prescaler terminal count while running.
- irq  out  1  = STATUS.match & CTRL.irq_en, combinational from registers.
- running  out  1  high in RUN state.

## Operation
- CTRL: bit0 enable, bit1 periodic, bit2 irq_en. COMPARE: 32-bit match value. SECONDS: count; any write loads wdata. STATUS: bit0 match (sticky, write 1 to clear), bit1 expired (read-only, high in EXPIRED).
- FSM states:
  - IDLE → RUN when enable=1.
  - RUN → IDLE when enable written 0.
  - RUN → EXPIRED on a one-shot match.
  - EXPIRED → IDLE when enable written 0.
  - EXPIRED → RUN on a SECONDS write while enable=1.
- In RUN, the prescaler counts 0..CLK_HZ-1 and then wraps to 0. On the wrap cycle tick=1 and next = seconds+1, modulo 2^32; wrap-around sets no flag.
- Match: on a tick with COMPARE≠0 and next==COMPARE, STATUS.match is set.
  - Periodic: seconds is loaded with 0 instead of COMPARE; the state stays RUN.
  - One-shot: seconds is loaded with COMPARE; CTRL.enable is cleared by hardware; the state goes to EXPIRED.
- COMPARE=0 disables matching.
- Leaving RUN clears the prescaler to 0; seconds holds its value. Entering RUN always starts the prescaler from 0.
- In IDLE and EXPIRED the prescaler and seconds are frozen and tick=0.
- Simultaneous events:
  - SECONDS write in the same cycle as a tick: the write wins, no match is evaluated, and the prescaler restarts at 0.
  - STATUS W1C in the same cycle as a new match: the set wins and match stays 1.
  - CTRL write clearing enable in the same cycle as a tick: the tick is suppressed and seconds is not incremented.
  - COMPARE write in the same cycle as a tick: the old COMPARE is used for that tick.
- Writing COMPARE below the current seconds gives no match until seconds wraps through 2^32.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, prescaler 0, all registers 0, seconds=0, tick=0, irq=0, running=0, rdata reflects zeroed registers.
- Register writes take effect at the next edge. rdata is valid in the same cycle as addr.
- Enable written at edge E: running=1 after E. The first tick is at edge E+CLK_HZ and is visible as tick high during cycle E+CLK_HZ-1..E+CLK_HZ. Subsequent ticks follow every CLK_HZ cycles.
- On the matching tick edge:
  - seconds, STATUS.match, irq and the state all update at that same edge, so irq rises 1 cycle after tick's high cycle.
  - One-shot: running falls at that same edge.
- reset_n asserted mid-count returns everything to reset values immediately. The first post-reset enable restarts the full CLK_HZ period.

## Test plan
- Basic count (CLK_HZ=4): write CTRL=1 → tick pulses every 4 cycles; seconds reads 1,2,3 after 4,8,12 cycles; running=1; irq=0.
- One-shot (CLK_HZ=4): COMPARE=3, CTRL=0b101 → after 12 cycles seconds=3, match=1, irq=1, running=0, STATUS=0b11, CTRL.enable reads 0. Seconds stays 3 for a further 20 cycles.
- Periodic and W1C: COMPARE=2, CTRL=0b111 → seconds sequence 1,0,1,0 with match set at each return to 0. Write STATUS=1 → irq drops next cycle. A W1C coincident with a match leaves match=1.
- Collisions: SECONDS write of 0xFFFFFFFF coincident with a tick → seconds=0xFFFFFFFF and the prescaler restarts; the next tick gives seconds=0 with no match flag (COMPARE=0). CTRL disable on a tick cycle → seconds unchanged.
- Reset mid-run: reset_n low at prescaler=2, seconds=5 → all outputs 0 asynchronously. After re-enable, the first tick arrives exactly 4 cycles later.
- Pause/resume: disable at prescaler=2 then re-enable → seconds held, and the next tick arrives 4 cycles after re-enable.

Source files
------------

// File: rtl/timer_ctrl.sv
// Seconds timer: a prescaler produces a once-per-second tick that advances a 32-bit
// seconds counter. A compare match raises an interrupt in one-shot or periodic mode.
module timer_ctrl #(
  parameter int CLK_HZ  = 80000000,
  parameter int PRESC_W = 27
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] seconds,
  output logic        tick,
  output logic        irq,
  output logic        running
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXP} state_t;

  localparam logic [PRESC_W-1:0] TERM = PRESC_W'(CLK_HZ - 1);

  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [31:0]         sec_q, sec_d;
  logic [31:0]         cmp_q, cmp_d;
  logic                en_q, en_d;
  logic                per_q, per_d;
  logic                irqen_q, irqen_d;
  logic                match_q, match_d;

  logic        ctrl_wr, cmp_wr, sec_wr, st_wr;
  logic        dis_wr, tick_int, match_ev;
  logic [31:0] sec_inc;

  assign ctrl_wr = wr_en && (addr == 2'd0);
  assign cmp_wr  = wr_en && (addr == 2'd1);
  assign sec_wr  = wr_en && (addr == 2'd2);
  assign st_wr   = wr_en && (addr == 2'd3);
  assign dis_wr  = ctrl_wr && !wdata[0];

  // A disable landing on the terminal count suppresses that tick entirely.
  assign tick_int = (state_q == S_RUN) && (presc_q == TERM) && !dis_wr;
  assign sec_inc  = sec_q + 32'd1;
  // The compare value used is the registered one, so a same-cycle COMPARE write applies later.
  assign match_ev = tick_int && !sec_wr && (cmp_q != 32'd0) && (sec_inc == cmp_q);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    cmp_d   = cmp_wr ? wdata : cmp_q;
    en_d    = ctrl_wr ? wdata[0] : en_q;
    per_d   = ctrl_wr ? wdata[1] : per_q;
    irqen_d = ctrl_wr ? wdata[2] : irqen_q;
    // Set wins over a coincident write-one-to-clear.
    match_d = match_ev || (match_q && !(st_wr && wdata[0]));

    if (sec_wr)         sec_d = wdata;
    else if (match_ev)  sec_d = per_q ? 32'd0 : cmp_q;
    else if (tick_int)  sec_d = sec_inc;

    case (state_q)
      S_IDLE: if (en_d) state_d = S_RUN;
      S_RUN: begin
        if (dis_wr) state_d = S_IDLE;
        else if (match_ev && !per_q) begin
          state_d = S_EXP;
          en_d    = 1'b0;
        end
      end
      S_EXP: begin
        if (dis_wr) state_d = S_IDLE;
        else if (sec_wr && en_q) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    // Prescaler only advances while staying in RUN; any entry or exit restarts it.
    if (state_q == S_RUN && state_d == S_RUN)
      presc_d = (presc_q == TERM) ? '0 : presc_q + PRESC_W'(1);
    else
      presc_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      sec_q   <= '0;
      cmp_q   <= '0;
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      irqen_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      per_q   <= per_d;
      irqen_q <= irqen_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata = {29'd0, irqen_q, per_q, en_q};
      2'd1: rdata = cmp_q;
      2'd2: rdata = sec_q;
      2'd3: rdata = {30'd0, (state_q == S_EXP), match_q};
      default: rdata = '0;
    endcase
  end

  assign seconds = sec_q;
  assign tick    = tick_int;
  assign irq     = match_q && irqen_q;
  assign running = (state_q == S_RUN);

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with CLK_HZ=4: stimulus queues the expected tick
// cycle and post-tick outputs, a monitor pops and compares on every tick.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata, seconds;
  logic        tick, irq, running;

  timer_ctrl #(.CLK_HZ(4), .PRESC_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .seconds(seconds), .tick(tick), .irq(irq), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] sec;
    logic        irq;
    logic        run;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [31:0] s, input logic i, input logic r);
    exp_t e;
    e.cyc = c; e.sec = s; e.irq = i; e.run = r;
    sb.push_back(e);
  endtask

  // Monitor: tick is sampled mid-low-phase, after the stimulus settles its inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (tick === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_tick", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("tick_cycle", 32'(cyc), 32'(e.cyc));
          @(posedge clk);
          #1;
          chk("tick_seconds", seconds, e.sec);
          chk("tick_irq", 32'(irq), 32'(e.irq));
          chk("tick_running", 32'(running), 32'(e.run));
        end
      end
    end
  end

  // Caller is positioned in the low phase; the write lands on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, rdata, exp);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int c;

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_seconds", seconds, 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_running", 32'(running), 0);
    rd("rst_ctrl", 2'd0, 0);
    rd("rst_cmp", 2'd1, 0);
    rd("rst_sec", 2'd2, 0);
    rd("rst_status", 2'd3, 0);
    @(negedge clk);

    // Basic count
    wr(2'd0, 32'd1); c = cyc;
    push(c + 3, 1, 0, 1); push(c + 7, 2, 0, 1); push(c + 11, 3, 0, 1);
    wait_until(c + 12);
    chk("basic_running", 32'(running), 1);
    chk("basic_irq", 32'(irq), 0);
    rd("basic_sec", 2'd2, 3);
    wr(2'd0, 32'd0);
    chk("basic_stop", 32'(running), 0);
    wr(2'd2, 32'd0);

    // One-shot
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd5); c = cyc;
    push(c + 3, 1, 0, 1); push(c + 7, 2, 0, 1); push(c + 11, 3, 1, 0);
    wait_until(c + 12);
    chk("os_seconds", seconds, 3);
    chk("os_irq", 32'(irq), 1);
    chk("os_running", 32'(running), 0);
    rd("os_status", 2'd3, 32'd3);
    rd("os_ctrl", 2'd0, 32'd4);
    repeat (20) @(negedge clk);
    chk("os_hold", seconds, 3);
    wr(2'd3, 32'd1);
    chk("os_w1c_irq", 32'(irq), 0);
    wr(2'd0, 32'd0);
    rd("os_idle_status", 2'd3, 0);
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd2);

    // Periodic with W1C, last W1C coincides with a match
    wr(2'd0, 32'd7); c = cyc;
    push(c + 3, 1, 0, 1);  push(c + 7, 0, 1, 1);
    push(c + 11, 1, 0, 1); push(c + 15, 0, 1, 1);
    push(c + 19, 1, 0, 1); push(c + 23, 0, 1, 1);
    wait_until(c + 9);
    wr(2'd3, 32'd1);
    chk("per_w1c1", 32'(irq), 0);
    wait_until(c + 17);
    wr(2'd3, 32'd1);
    chk("per_w1c2", 32'(irq), 0);
    wait_until(c + 23);
    wr(2'd3, 32'd1);
    chk("per_w1c_vs_set", 32'(irq), 1);
    wr(2'd0, 32'd0);
    rd("per_status", 2'd3, 32'd1);
    wr(2'd3, 32'd1);
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd0);

    // Collisions: SECONDS write on a tick, then disable on a tick
    wr(2'd0, 32'd1); c = cyc;
    push(c + 3, 1, 0, 1); push(c + 7, 32'hFFFF_FFFF, 0, 1); push(c + 11, 0, 0, 1);
    wait_until(c + 7);
    wr(2'd2, 32'hFFFF_FFFF);
    wait_until(c + 15);
    wr(2'd0, 32'd0);
    chk("col_dis_sec", seconds, 0);
    chk("col_dis_run", 32'(running), 0);
    rd("col_status", 2'd3, 0);

    // Reset mid-run at prescaler=2, seconds=5
    wr(2'd2, 32'd4);
    wr(2'd0, 32'd1); c = cyc;
    push(c + 3, 5, 0, 1);
    wait_until(c + 6);
    chk("pre_rst_sec", seconds, 5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sec", seconds, 0);
    chk("mid_rst_run", 32'(running), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    chk("mid_rst_tick", 32'(tick), 0);
    rd("mid_rst_ctrl", 2'd0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wr(2'd0, 32'd1); c = cyc;
    push(c + 3, 1, 0, 1);

    // Pause at prescaler=2, resume
    wait_until(c + 6);
    wr(2'd0, 32'd0);
    chk("pause_run", 32'(running), 0);
    repeat (3) @(negedge clk);
    chk("pause_hold", seconds, 1);
    wr(2'd0, 32'd1); c = cyc;
    push(c + 3, 2, 0, 1);
    wait_until(c + 4);
    wr(2'd0, 32'd0);
    repeat (8) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
